// File: rtl/ac_lookup_ctrl.sv
// ac_lookup_ctrl: handshaked Aho-Corasick sequencer driving the goto and failure table RAMs,
// following failure links on goto misses and reporting the landing state plus its output flag.
module ac_lookup_ctrl #(
    parameter int                 STATE_W   = 8,
    parameter int                 CHAR_W    = 4,
    parameter logic [STATE_W-1:0] FAIL_CODE = '1,
    parameter int                 MAX_HOPS  = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_initialize,
    input  logic                      i_char_valid,
    input  logic [CHAR_W-1:0]         i_char,
    output logic                      o_char_ready,
    output logic                      o_g_rd_en,
    output logic [STATE_W+CHAR_W-1:0] o_g_addr,
    input  logic [STATE_W-1:0]        i_g_rd_data,
    output logic                      o_f_rd_en,
    output logic [STATE_W-1:0]        o_f_addr,
    input  logic [STATE_W:0]          i_f_rd_data,
    output logic                      o_res_valid,
    output logic [STATE_W-1:0]        o_res_state,
    output logic                      o_match,
    output logic                      o_err
);
    localparam int HOP_W = $clog2(MAX_HOPS + 1);

    typedef enum logic [2:0] {IDLE, G_RD, G_CHK, F_RD, F_CHK, O_RD, O_CHK} state_t;

    state_t             r_state, w_next;
    logic [STATE_W-1:0] r_cur_state;
    logic [CHAR_W-1:0]  r_char;
    logic [HOP_W-1:0]   r_hops;
    logic               r_res_valid, r_match, r_err;
    logic [STATE_W-1:0] r_res_state;
    logic               w_miss, w_root, w_limit;

    assign w_miss  = i_g_rd_data == FAIL_CODE;
    assign w_root  = r_cur_state == '0;
    assign w_limit = r_hops == HOP_W'(MAX_HOPS);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else r_state <= w_next;
    end

    // the root has no failure link, so a root miss lands directly on the root
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_char_valid ? G_RD : IDLE;
            G_RD:    w_next = G_CHK;
            G_CHK:   w_next = (!w_miss || w_root || w_limit) ? O_RD : F_RD;
            F_RD:    w_next = F_CHK;
            F_CHK:   w_next = G_RD;
            O_RD:    w_next = O_CHK;
            O_CHK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_char_ready = r_state == IDLE;
        o_g_rd_en    = r_state == G_RD;
        o_f_rd_en    = r_state == F_RD || r_state == O_RD;
    end

    assign o_g_addr    = {r_cur_state, r_char};
    assign o_f_addr    = r_cur_state;
    assign o_res_valid = r_res_valid;
    assign o_res_state = r_res_state;
    assign o_match     = r_match;
    assign o_err       = r_err;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur_state <= '0;
            r_char      <= '0;
            r_hops      <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_state <= '0;
            r_match     <= 1'b0;
        end else begin
            r_res_valid <= r_state == O_CHK;
            r_match     <= r_state == O_CHK && i_f_rd_data[STATE_W];
            if (r_state == O_CHK) r_res_state <= r_cur_state;
            case (r_state)
                IDLE: begin
                    if (i_initialize) begin
                        r_cur_state <= '0;
                        r_err       <= 1'b0;
                    end
                    if (i_char_valid) begin
                        r_char <= i_char;
                        r_hops <= '0;
                    end
                end
                G_CHK: begin
                    if (!w_miss) r_cur_state <= i_g_rd_data;
                    else if (w_root) r_cur_state <= '0;
                    else if (w_limit) begin
                        r_err       <= 1'b1;
                        r_cur_state <= '0;
                    end else r_hops <= r_hops + HOP_W'(1);
                end
                F_CHK:   r_cur_state <= i_f_rd_data[STATE_W-1:0];
                default: ;
            endcase
        end
    end
endmodule
